// File: rtl/hack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hack_pkg
// Purpose  : Shared definitions for the Hack run/debug sequencer: FSM state
//            encoding and default widths.
// Revision : 1.0 - initial release
// ============================================================================
package hack_pkg;

  localparam int C_DEFAULT_AW = 15;  // instruction ROM address width
  localparam int C_DEFAULT_CW = 32;  // executed-instruction counter width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RST  = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4,
    S_STEP = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hack_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : hack_rom_loader
// Purpose  : Pairs a big-endian byte stream into 16-bit instruction words and
//            writes them to consecutive ROM addresses starting at 0.
// Ports    : i_active      - sequencer is in LOAD (gates rx_ready)
//            i_start       - entering LOAD: clear address, count, phase, full
//            i_abort       - leaving LOAD on a command: drop any odd byte
//            i_rx_data/valid, o_rx_ready - byte stream handshake
//            o_rom_we/waddr/wdata        - ROM write port (registered)
//            o_load_words  - words written since the last i_start
//            o_full        - last ROM word has been accepted
// Revision : 1.0 - initial release
// ============================================================================
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int AW = C_DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_active,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic          o_rom_we,
  output logic [AW-1:0] o_rom_waddr,
  output logic [15:0]   o_rom_wdata,
  output logic [AW:0]   o_load_words,
  output logic          o_full
);

  logic          r_phase_lo;  // 0: next byte is the high byte
  logic [7:0]    r_hi;
  logic          r_full;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [15:0]   r_wdata;
  logic [AW:0]   r_words;
  logic          w_accept;

  // Ready depends only on registered state, never on rx_valid.
  assign o_rx_ready = i_active & ~r_full;
  // A byte arriving in the same cycle as an abort is dropped with the pair.
  assign w_accept   = i_rx_valid & o_rx_ready & ~i_abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase_lo <= 1'b0;
      r_hi       <= 8'h00;
      r_full     <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 16'h0000;
      r_words    <= '0;
    end else begin
      r_we <= 1'b0;
      if (i_start) begin
        r_phase_lo <= 1'b0;
        r_full     <= 1'b0;
        r_waddr    <= '0;
        r_words    <= '0;
      end else begin
        // The address shown during the strobe is the word index; it advances
        // once the strobe has been presented. A new pair needs two accepted
        // bytes, so the next strobe always sees the advanced address.
        if (r_we) begin
          r_waddr <= r_waddr + 1'b1;
          r_words <= r_words + 1'b1;
        end
        if (i_abort) begin
          r_phase_lo <= 1'b0;
        end else if (w_accept) begin
          if (!r_phase_lo) begin
            r_hi       <= i_rx_data;
            r_phase_lo <= 1'b1;
          end else begin
            r_phase_lo <= 1'b0;
            r_we       <= 1'b1;
            r_wdata    <= {r_hi, i_rx_data};
            if (&r_waddr) begin
              r_full <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign o_rom_we     = r_we;
  assign o_rom_waddr  = r_waddr;
  assign o_rom_wdata  = r_wdata;
  assign o_load_words = r_words;
  assign o_full       = r_full;

endmodule
`default_nettype wire

// File: rtl/hack_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hack_run_ctrl
// Purpose  : Run/debug sequencer for the Hack CPU. Owns CPU reset and clock
//            enable, loads instruction ROM from a byte stream, and provides
//            halt, single-step, resume and one PC breakpoint.
// Ports    : cmd_run/halt/step/load - host command pulses
//            rx_data/valid/ready    - ROM load byte stream
//            rom_we/waddr/wdata     - instruction ROM write port
//            cpu_pc, bp_en, bp_addr - breakpoint compare inputs
//            cpu_reset, cpu_ce      - CPU control (cpu_ce is combinational)
//            state, load_words, icount - status
// Revision : 1.0 - initial release
// ============================================================================
module hack_run_ctrl
  import hack_pkg::*;
#(
  parameter int AW = C_DEFAULT_AW,
  parameter int CW = C_DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_run,
  input  logic          cmd_halt,
  input  logic          cmd_step,
  input  logic          cmd_load,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          rom_we,
  output logic [AW-1:0] rom_waddr,
  output logic [15:0]   rom_wdata,
  input  logic [AW-1:0] cpu_pc,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  output logic          cpu_reset,
  output logic          cpu_ce,
  output logic [2:0]    state,
  output logic [AW:0]   load_words,
  output logic [CW-1:0] icount
);

  state_e        r_state;
  logic          r_cpu_reset;
  logic          r_skip;      // suppress the breakpoint for the first RUN cycle after resume
  logic [CW-1:0] r_icount;
  logic          w_bp_hit;
  logic          w_cpu_ce;
  logic          w_load_active;
  logic          w_load_start;
  logic          w_load_abort;
  logic          w_load_full;

  assign w_bp_hit = bp_en & (cpu_pc == bp_addr) & ~r_skip;

  // The enable drops in the same cycle as a hit or halt so the instruction at
  // the current PC is not executed.
  always_comb begin
    w_cpu_ce = 1'b0;
    case (r_state)
      S_RST, S_STEP: w_cpu_ce = 1'b1;
      S_RUN:         w_cpu_ce = ~(w_bp_hit | cmd_halt);
      default:       w_cpu_ce = 1'b0;
    endcase
  end

  assign w_load_active = (r_state == S_LOAD);
  // LOAD is reachable only from IDLE and HALT, and cmd_load wins there.
  assign w_load_start  = ((r_state == S_IDLE) | (r_state == S_HALT)) & cmd_load;
  assign w_load_abort  = w_load_active & (cmd_halt | cmd_run);

  hack_rom_loader #(
    .AW (AW)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .i_active     (w_load_active),
    .i_start      (w_load_start),
    .i_abort      (w_load_abort),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_rx_ready   (rx_ready),
    .o_rom_we     (rom_we),
    .o_rom_waddr  (rom_waddr),
    .o_rom_wdata  (rom_wdata),
    .o_load_words (load_words),
    .o_full       (w_load_full)
  );

  // Illegal commands per state are simply not decoded; among the legal ones
  // halt > load > step > run.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpu_reset <= 1'b1;
      r_skip      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_load) begin
            r_state <= S_LOAD;
          end else if (cmd_run) begin
            r_state <= S_RST;
          end
        end
        S_LOAD: begin
          if (cmd_halt) begin
            r_state <= S_IDLE;
          end else if (cmd_run) begin
            r_state <= S_RST;
          end else if (w_load_full) begin
            r_state <= S_IDLE;
          end
        end
        S_RST: begin
          r_state     <= S_RUN;
          r_cpu_reset <= 1'b0;
          r_skip      <= 1'b0;
        end
        S_RUN: begin
          r_skip <= 1'b0;
          if (cmd_halt | w_bp_hit) begin
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          if (cmd_load) begin
            r_state     <= S_LOAD;
            r_cpu_reset <= 1'b1;
          end else if (cmd_step) begin
            r_state <= S_STEP;
          end else if (cmd_run) begin
            r_state <= S_RUN;
            r_skip  <= 1'b1;
          end
        end
        S_STEP: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cpu_reset <= 1'b1;
          r_skip      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_icount <= '0;
    end else if (r_state == S_RST) begin
      r_icount <= '0;
    end else if (w_cpu_ce && !r_cpu_reset) begin
      r_icount <= r_icount + 1'b1;
    end
  end

  assign cpu_ce    = w_cpu_ce;
  assign cpu_reset = r_cpu_reset;
  assign state     = r_state;
  assign icount    = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_hack_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_run_ctrl
// Purpose  : Self-checking bench for hack_run_ctrl. A full-size instance
//            (AW=15) and a small instance (AW=2, for the ROM-full case) share
//            stimulus. A simple CPU model advances the PC on cpu_ce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_run_ctrl;

  localparam int AW  = 15;
  localparam int CW  = 32;
  localparam int SAW = 2;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RST  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_HALT = 3'd4;
  localparam logic [2:0] ST_STEP = 3'd5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_run = 1'b0, cmd_halt = 1'b0, cmd_step = 1'b0, cmd_load = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic [AW-1:0] cpu_pc;

  logic          rx_ready, rom_we, cpu_reset, cpu_ce;
  logic [AW-1:0] rom_waddr;
  logic [15:0]   rom_wdata;
  logic [2:0]    state;
  logic [AW:0]   load_words;
  logic [CW-1:0] icount;

  logic           s_rx_ready, s_rom_we, s_cpu_reset, s_cpu_ce;
  logic [SAW-1:0] s_rom_waddr;
  logic [15:0]    s_rom_wdata;
  logic [2:0]     s_state;
  logic [SAW:0]   s_load_words;
  logic [CW-1:0]  s_icount;
  logic [SAW-1:0] s_pc, s_bp;

  int checks = 0;
  int failures = 0;

  logic [31:0] wq_b[$];
  logic [31:0] wq_s[$];

  always #5 clk = ~clk;

  assign s_pc = cpu_pc[SAW-1:0];
  assign s_bp = bp_addr[SAW-1:0];

  hack_run_ctrl #(.AW(AW), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .cmd_load(cmd_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rom_we(rom_we),
    .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .cpu_pc(cpu_pc),
    .bp_en(bp_en), .bp_addr(bp_addr), .cpu_reset(cpu_reset), .cpu_ce(cpu_ce),
    .state(state), .load_words(load_words), .icount(icount)
  );

  hack_run_ctrl #(.AW(SAW), .CW(CW)) u_small (
    .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_halt(cmd_halt),
    .cmd_step(cmd_step), .cmd_load(cmd_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(s_rx_ready), .rom_we(s_rom_we),
    .rom_waddr(s_rom_waddr), .rom_wdata(s_rom_wdata), .cpu_pc(s_pc),
    .bp_en(bp_en), .bp_addr(s_bp), .cpu_reset(s_cpu_reset), .cpu_ce(s_cpu_ce),
    .state(s_state), .load_words(s_load_words), .icount(s_icount)
  );

  // Minimal CPU model: PC clears under cpu_reset, otherwise advances by one
  // per enabled cycle (straight-line code).
  always @(posedge clk) begin
    if (reset) cpu_pc <= '0;
    else if (cpu_ce) cpu_pc <= cpu_reset ? '0 : cpu_pc + 1'b1;
  end

  // Every cycle the strobe is high is one recorded write.
  always @(posedge clk) begin
    if (rom_we)   wq_b.push_back({1'b0, rom_waddr, rom_wdata});
    if (s_rom_we) wq_s.push_back({14'd0, s_rom_waddr, s_rom_wdata});
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_run = 0; cmd_halt = 0; cmd_step = 0; cmd_load = 0;
    rx_valid = 1'b0; bp_en = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sel);
    int n = 0;
    while (!(sel ? s_rx_ready : rx_ready) && n < 20) begin cyc(); n++; end
    checks++; if (n >= 20) begin failures++; $display("FAIL rx_ready_wait got=0 exp=1"); end
    rx_data = b; rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 1)) cyc();
  endtask

  // Expected writes: word i = {byte[2i], byte[2i+1]} at address i.
  task automatic check_writes(input logic [7:0] bytes[$], input int k, input bit sel, input string tag);
    logic [31:0] e, g;
    int sz;
    sz = sel ? wq_s.size() : wq_b.size();
    checks++; if (sz != k) begin failures++; $display("FAIL %s_nwrites got=%0d exp=%0d", tag, sz, k); end
    for (int i = 0; i < k; i++) begin
      if (i < sz) begin
        e = {16'(i), bytes[2*i], bytes[2*i+1]};
        g = sel ? wq_s[i] : wq_b[i];
        checks++; if (g !== e) begin failures++; $display("FAIL %s_write%0d got=%h exp=%h", tag, i, g, e); end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL rst_cpu_reset got=%b exp=1", cpu_reset); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL rst_cpu_ce got=%b exp=0", cpu_ce); end
    checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rst_rx_ready got=%b exp=0", rx_ready); end
    checks++; if (rom_we !== 1'b0) begin failures++; $display("FAIL rst_rom_we got=%b exp=0", rom_we); end
    checks++; if (rom_waddr !== '0 || rom_wdata !== 16'h0) begin failures++; $display("FAIL rst_rom_bus got=%h/%h exp=0/0", rom_waddr, rom_wdata); end
    checks++; if (load_words !== '0) begin failures++; $display("FAIL rst_load_words got=%0d exp=0", load_words); end
    checks++; if (icount !== '0) begin failures++; $display("FAIL rst_icount got=%0d exp=0", icount); end
    reset = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [7:0] bytes[$];
    bytes = '{8'h12, 8'h34, 8'h00, 8'h05};
    wq_b.delete();
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    checks++; if (state !== ST_LOAD) begin failures++; $display("FAIL load_state got=%0d exp=1", state); end
    checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL load_rx_ready got=%b exp=1", rx_ready); end
    foreach (bytes[i]) begin
      send_byte(bytes[i], 1'b0);
      checks++; if (cpu_reset !== 1'b1) begin failures++; $display("FAIL load_cpu_reset got=%b exp=1", cpu_reset); end
    end
    repeat (2) cyc();
    check_writes(bytes, 2, 1'b0, "load_basic");
    checks++; if (load_words !== 16'd2) begin failures++; $display("FAIL load_words got=%0d exp=2", load_words); end
  endtask

  task automatic test_random_load();
    logic [7:0] bytes[$];
    int k;
    bit odd;
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(1, 5);
      odd = 1'($urandom_range(0, 1));
      bytes.delete();
      for (int i = 0; i < 2 * k + (odd ? 1 : 0); i++) bytes.push_back(8'($urandom));
      wq_b.delete();
      cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
      repeat (2) cyc();
      cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
      cyc();
      checks++; if (state !== ST_IDLE) begin failures++; $display("FAIL rload_state got=%0d exp=0", state); end
      check_writes(bytes, k, 1'b0, "rload");
      checks++; if (load_words !== 16'(k)) begin failures++; $display("FAIL rload_words got=%0d exp=%0d", load_words, k); end
    end
  endtask

  task automatic test_load_run();
    logic [7:0] bytes[$];
    int n;
    bytes.delete();
    for (int i = 0; i < 3; i++) bytes.push_back(8'($urandom));
    wq_b.delete();
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    foreach (bytes[i]) send_byte(bytes[i], 1'b0);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    checks++; if (state !== ST_RST) begin failures++; $display("FAIL lr_state_rst got=%0d exp=2", state); end
    checks++; if (cpu_ce !== 1'b1 || cpu_reset !== 1'b1) begin failures++; $display("FAIL lr_rst_ctl got=%b%b exp=11", cpu_ce, cpu_reset); end
    check_writes(bytes, 1, 1'b0, "lr");
    n = $urandom_range(4, 20);
    repeat (n + 1) cyc();
    checks++; if (state !== ST_RUN || cpu_reset !== 1'b0) begin failures++; $display("FAIL lr_run got=%0d/%b exp=3/0", state, cpu_reset); end
    checks++; if (icount !== CW'(n)) begin failures++; $display("FAIL lr_icount got=%0d exp=%0d", icount, n); end
    checks++; if (cpu_pc !== AW'(n)) begin failures++; $display("FAIL lr_pc got=%0d exp=%0d", cpu_pc, n); end
    cmd_halt = 1'b1; #1;
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL lr_halt_ce got=%b exp=0", cpu_ce); end
    cyc(); cmd_halt = 1'b0;
    checks++; if (state !== ST_HALT || icount !== CW'(n)) begin failures++; $display("FAIL lr_halted got=%0d/%0d exp=4/%0d", state, icount, n); end
  endtask

  task automatic test_breakpoint(input int bp);
    int n = 0;
    do_reset();
    bp_en = 1'b1; bp_addr = AW'(bp);
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    while (!(state == ST_RUN && cpu_pc == AW'(bp)) && n < 100) begin cyc(); n++; end
    checks++; if (n >= 100) begin failures++; $display("FAIL bp_reach got=%0d exp=%0d", cpu_pc, bp); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL bp_hit_ce got=%b exp=0", cpu_ce); end
    cyc();
    checks++; if (state !== ST_HALT) begin failures++; $display("FAIL bp_state got=%0d exp=4", state); end
    checks++; if (icount !== CW'(bp) || cpu_pc !== AW'(bp)) begin failures++; $display("FAIL bp_count got=%0d/%0d exp=%0d", icount, cpu_pc, bp); end
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    checks++; if (state !== ST_RUN || cpu_ce !== 1'b1) begin failures++; $display("FAIL bp_resume got=%0d/%b exp=3/1", state, cpu_ce); end
    repeat (3) cyc();
    checks++; if (state !== ST_RUN || cpu_pc !== AW'(bp + 3)) begin failures++; $display("FAIL bp_past got=%0d/%0d exp=3/%0d", state, cpu_pc, bp + 3); end
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    checks++; if (state !== ST_HALT || icount !== CW'(bp + 3)) begin failures++; $display("FAIL bp_halt2 got=%0d/%0d exp=4/%0d", state, icount, bp + 3); end
  endtask

  task automatic test_step(input int base);
    bp_addr = AW'(base);  // breakpoint on the current PC must not block a step
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1; #1;
      checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL step_pre_ce got=%b exp=0", cpu_ce); end
      cyc(); cmd_step = 1'b0;
      checks++; if (state !== ST_STEP || cpu_ce !== 1'b1) begin failures++; $display("FAIL step_in got=%0d/%b exp=5/1", state, cpu_ce); end
      cyc();
      checks++; if (state !== ST_HALT || cpu_ce !== 1'b0) begin failures++; $display("FAIL step_out got=%0d/%b exp=4/0", state, cpu_ce); end
    end
    checks++; if (icount !== CW'(base + 3) || cpu_pc !== AW'(base + 3)) begin failures++; $display("FAIL step_count got=%0d/%0d exp=%0d", icount, cpu_pc, base + 3); end
  endtask

  task automatic test_priority();
    bp_en = 1'b0;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    checks++; if (state !== ST_RUN) begin failures++; $display("FAIL pri_run got=%0d exp=3", state); end
    cmd_halt = 1'b1; cmd_load = 1'b1; #1;
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL pri_halt_ce got=%b exp=0", cpu_ce); end
    cyc(); cmd_halt = 1'b0; cmd_load = 1'b0;
    checks++; if (state !== ST_HALT || rx_ready !== 1'b0) begin failures++; $display("FAIL pri_halt_wins got=%0d/%b exp=4/0", state, rx_ready); end
    cmd_step = 1'b1; cmd_load = 1'b1; cyc(); cmd_step = 1'b0; cmd_load = 1'b0;
    checks++; if (state !== ST_LOAD || cpu_reset !== 1'b1) begin failures++; $display("FAIL pri_load_wins got=%0d/%b exp=1/1", state, cpu_reset); end
    cmd_halt = 1'b1; cyc(); cmd_halt = 1'b0;
    cmd_step = 1'b1; cyc(); cmd_step = 1'b0;
    cyc();
    checks++; if (state !== ST_IDLE || cpu_ce !== 1'b0) begin failures++; $display("FAIL pri_idle_step got=%0d/%b exp=0/0", state, cpu_ce); end
  endtask

  task automatic test_full();
    logic [7:0] bytes[$];
    do_reset();
    wq_s.delete();
    bytes.delete();
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    for (int i = 0; i < 7; i++) send_byte(bytes[i], 1'b1);
    checks++; if (s_rx_ready !== 1'b1) begin failures++; $display("FAIL full_ready_before got=%b exp=1", s_rx_ready); end
    rx_data = bytes[7]; rx_valid = 1'b1; cyc(); rx_valid = 1'b0;
    checks++; if (s_rx_ready !== 1'b0 || s_rom_we !== 1'b1 || s_rom_waddr !== 2'd3) begin failures++; $display("FAIL full_last got=%b%b/%0d exp=01/3", s_rx_ready, s_rom_we, s_rom_waddr); end
    repeat (2) cyc();
    checks++; if (s_state !== ST_IDLE) begin failures++; $display("FAIL full_state got=%0d exp=0", s_state); end
    checks++; if (s_load_words !== 3'd4 || s_rx_ready !== 1'b0) begin failures++; $display("FAIL full_words got=%0d/%b exp=4/0", s_load_words, s_rx_ready); end
    check_writes(bytes, 4, 1'b1, "full");
  endtask

  task automatic test_reset_mid();
    int nb, ns;
    cmd_load = 1'b1; cyc(); cmd_load = 1'b0;
    send_byte(8'hA5, 1'b0);
    nb = wq_b.size(); ns = wq_s.size();
    rx_data = 8'h5A; rx_valid = 1'b1; reset = 1'b1;
    cyc(); rx_valid = 1'b0;
    repeat (2) cyc();
    checks++; if (wq_b.size() != nb || wq_s.size() != ns) begin failures++; $display("FAIL rmid_writes got=%0d/%0d exp=%0d/%0d", wq_b.size(), wq_s.size(), nb, ns); end
    checks++; if (state !== ST_IDLE || rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin failures++; $display("FAIL rmid_ctl got=%0d/%b/%b exp=0/0/1", state, rx_ready, cpu_reset); end
    checks++; if (rom_waddr !== '0 || rom_wdata !== 16'h0 || load_words !== '0) begin failures++; $display("FAIL rmid_rom got=%h/%h/%0d exp=0/0/0", rom_waddr, rom_wdata, load_words); end
    reset = 1'b0;
    cmd_run = 1'b1; cyc(); cmd_run = 1'b0;
    repeat (6) cyc();
    reset = 1'b1; cyc();
    checks++; if (state !== ST_IDLE || icount !== '0 || cpu_ce !== 1'b0 || cpu_reset !== 1'b1) begin failures++; $display("FAIL rrun got=%0d/%0d/%b/%b exp=0/0/0/1", state, icount, cpu_ce, cpu_reset); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_random_load();
    test_load_run();
    test_breakpoint(7);
    test_step(10);
    test_breakpoint($urandom_range(0, 12));
    test_priority();
    test_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hack_run_ctrl.md
Name: hack_run_ctrl

Overview:
Run/debug sequencer for the Hack CPU core. It owns the core's reset and clock-enable, and loads instruction ROM from a byte stream (UART receiver). It also provides halt, single-step, resume and one hardware PC breakpoint. It sits between the host-command decoder and the CPU/ROM pair. All CPU and data-RAM register updates in the top level are qualified by cpu_ce.

Parameters:
AW, 15, instruction ROM address width (ROM depth = 2**AW words)
CW, 32, width of executed-instruction counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high block reset
cmd_run  input  1  pulse: start from PC 0 (IDLE) or resume (HALT)
cmd_halt  input  1  pulse: stop execution / abort load
cmd_step  input  1  pulse: execute exactly one instruction (HALT only)
cmd_load  input  1  pulse: enter ROM load, write address restarts at 0
rx_data  input  8  load byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  byte accepted when rx_valid&rx_ready
rom_we  output  1  instruction ROM write strobe
rom_waddr  output  AW  ROM write address
rom_wdata  output  16  ROM write data
cpu_pc  input  AW  current CPU program counter
bp_en  input  1  breakpoint enable
bp_addr  input  AW  breakpoint PC
cpu_reset  output  1  reset to CPU core
cpu_ce  output  1  CPU clock enable
state  output  3  encoded FSM state
load_words  output  AW+1  words written in the current/last load
icount  output  CW  instructions executed since last RST

Behaviour:
- Reset ("reset reset, synchronous, active-high; clock clk"): state=IDLE, cpu_reset=1, cpu_ce=0, rx_ready=0, rom_we=0, rom_waddr=0, rom_wdata=0, load_words=0, icount=0, byte-phase=high, skip=0.
- State encoding: IDLE=0, LOAD=1, RST=2, RUN=3, HALT=4, STEP=5.
- Command priority in one cycle: halt > load > step > run. Commands that are not legal in the current state are ignored.
- IDLE: cpu_reset=1, cpu_ce=0. cmd_load -> LOAD. cmd_run -> RST.
- LOAD: cpu_reset=1, cpu_ce=0, rx_ready=1.
  - Bytes pair big-endian: the first accepted byte is latched as the high byte. On the second byte, the next cycle has rom_we=1 for exactly 1 cycle, with rom_wdata={hi,lo} and rom_waddr=word index.
  - After each write, the word index and load_words increment. Entry into LOAD clears both, plus byte-phase.
  - Full: after word 2**AW-1 is written, go to IDLE. load_words=2**AW, rx_ready=0 from the cycle after the last byte is accepted.
  - cmd_halt -> IDLE. cmd_run -> RST. Either discards a pending odd byte; no partial write.
- RST: cpu_reset=1, cpu_ce=1 for exactly 1 cycle (PC, A and D go to 0). icount is cleared. Next state is RUN.
- RUN: cpu_reset=0, cpu_ce=1.
  - Breakpoint hit = bp_en & (cpu_pc==bp_addr) & ~skip. On a hit, cpu_ce=0 in that same cycle (combinational), so the instruction at bp_addr is not executed; next state is HALT.
  - cmd_halt: cpu_ce=0 that cycle, next state HALT.
  - skip clears after the first RUN cycle.
- HALT: cpu_reset=0, cpu_ce=0.
  - cmd_run -> RUN with skip=1, so resume executes past a breakpoint on the current PC.
  - cmd_step -> STEP.
  - cmd_load -> LOAD.
- STEP: cpu_ce=1 for exactly 1 cycle, breakpoints ignored, then HALT.
- icount increments on every cycle with cpu_ce=1 and cpu_reset=0. It wraps modulo 2**CW.
- reset mid-LOAD or mid-RUN forces the reset values next cycle. No rom_we is emitted after reset is sampled.
- All outputs are registered except cpu_ce and rx_ready. Those are decoded from state plus breakpoint and cmd_halt, with no combinational path from rx_valid.

Decomposition:
- Shared package hack_pkg: state encoding constants, default AW.
- One sub-module, hack_rom_loader: byte pairing, write strobe, address/count, full detect. It is enabled by the FSM and returns done/full.
- The FSM, breakpoint compare and icount stay in the top.

Test Plan:
- After reset, cmd_load, then bytes 0x12,0x34,0x00,0x05 -> rom_we pulses twice: (addr 0, 0x1234) and (addr 1, 0x0005); load_words=2; cpu_reset stays 1 throughout.
- LOAD with 3 bytes, then cmd_run -> exactly 1 write; RST for 1 cycle with cpu_ce=1; then RUN. icount=N after N RUN cycles.
- RUN with bp_en=1, bp_addr=7; CPU counts PC 0..7 -> cpu_ce=0 in the cycle cpu_pc=7; state=HALT; icount=7. cmd_run -> PC 7 executes (skip), no re-hit.
- In HALT, three cmd_step pulses -> three single-cycle cpu_ce pulses; icount +3; state returns to HALT each time.
- Same-cycle cmd_halt and cmd_load in RUN -> HALT (halt wins); cmd_step in IDLE is ignored.
- With AW=2, load 8 bytes -> 4 writes; IDLE entered; load_words=4; rx_ready=0 afterwards. Assert reset mid-LOAD -> no further rom_we, all outputs at reset values.
